// File: rtl/line_buffer_control_generic.sv
// line_buffer_control_generic: window/padding control for a column-major K x K line buffer.
// Ports: clk, rst (async, active-high); sof restarts a frame; input_valid marks a pixel;
//   busy is high while internal flush ticks drain the last columns; output_valid qualifies
//   is_pad (per-tap padding flags, bit kx*K+ky), out_x/out_y (window centre);
//   frame_done flags the last window of a frame.
module line_buffer_control_generic #(
  parameter int IN_H = 3,
  parameter int IN_W = 3,
  parameter int K = 3,
  parameter int STRIDE = 1,
  parameter bit PAD_SAME = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic sof,
  input  logic input_valid,
  output logic busy,
  output logic output_valid,
  output logic [K*K-1:0] is_pad,
  output logic [11:0] out_x,
  output logic [11:0] out_y,
  output logic frame_done
);
  localparam int P = (K - 1) / 2;
  localparam int L = P * IN_H + P;
  localparam int N = IN_H * IN_W;
  localparam int CW = $clog2(N + L + 1);
  localparam bit FL = PAD_SAME && P > 0;
  // Parity of emitted centres when STRIDE = 2.
  localparam bit PH = PAD_SAME ? 1'b0 : P % 2 == 1;
  // Last emitted centre; the frame ends on the tick that addresses it.
  localparam int LX = PAD_SAME ? ((IN_W - 1) / STRIDE) * STRIDE : P + ((IN_W - 1 - 2 * P) / STRIDE) * STRIDE;
  localparam int LY = PAD_SAME ? ((IN_H - 1) / STRIDE) * STRIDE : P + ((IN_H - 1 - 2 * P) / STRIDE) * STRIDE;
  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] t;
  logic [11:0] cx, cy;
  logic tick, addr, emit, last, in_x, in_y, ph;
  logic [K*K-1:0] pad;
  assign busy = state == FLUSH;
  assign tick = busy || ((state == FILL || state == RUN) && input_valid);
  // Ticks before L only prime the line buffer; afterwards each tick addresses the next centre.
  assign addr = tick && int'(t) >= L;
  assign in_x = PAD_SAME || (int'(cx) >= P && int'(cx) <= IN_W - 1 - P);
  assign in_y = PAD_SAME || (int'(cy) >= P && int'(cy) <= IN_H - 1 - P);
  assign ph = STRIDE == 1 || (cx[0] == PH && cy[0] == PH);
  assign emit = addr && in_x && in_y && ph;
  assign last = emit && int'(cx) == LX && int'(cy) == LY;
  for (genvar i = 0; i < K; i++) begin : g_x
    for (genvar j = 0; j < K; j++) begin : g_y
      assign pad[i*K+j] = PAD_SAME && (int'(cx) + i - P < 0 || int'(cx) + i - P > IN_W - 1 ||
                                       int'(cy) + j - P < 0 || int'(cy) + j - P > IN_H - 1);
    end
  end
  always_comb begin
    state_n = state;
    if (sof) state_n = FILL;
    else if (last) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
    else if (state == FILL && (int'(t) >= L || (tick && int'(t) == L - 1))) state_n = RUN;
    else if (state == RUN && FL && tick && int'(t) == N - 1) state_n = FLUSH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      t <= '0;
      cx <= '0;
      cy <= '0;
      output_valid <= 1'b0;
      frame_done <= 1'b0;
      is_pad <= '0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      state <= state_n;
      output_valid <= !sof && emit;
      frame_done <= !sof && last;
      if (sof) begin
        t <= CW'(input_valid);
        cx <= '0;
        cy <= '0;
        is_pad <= '0;
        out_x <= '0;
        out_y <= '0;
      end else begin
        if (tick) t <= t + CW'(1);
        if (addr) begin
          cy <= int'(cy) == IN_H - 1 ? '0 : cy + 12'd1;
          cx <= (int'(cy) == IN_H - 1 && int'(cx) != IN_W - 1) ? cx + 12'd1 : cx;
        end
        if (emit) begin
          is_pad <= pad;
          out_x <= cx;
          out_y <= cy;
        end
      end
    end
  end
endmodule
